// File: rtl/enable_monitor_pkg.sv
// Shared types and constants for the enable overlap monitor.
// Pulled in by the interface, the divider and the top.
package enable_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    DIVIDE,
    DONE
  } mon_state_e;

  localparam int PCT_W     = 7;
  localparam int PCT_SCALE = 100;
  localparam int DIV_STEPS = 7;

endpackage

// File: rtl/enable_overlap_monitor_if.sv
// Enable inputs, window control and measurement results.
// master drives enables/controls, slave is the monitor.
interface enable_overlap_monitor_if #(
  parameter int CNT_W = 16
);
  import enable_monitor_pkg::*;

  logic             ens;
  logic             enr;
  logic             start;
  logic             stop;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] send_cycles;
  logic [CNT_W-1:0] recv_cycles;
  logic [CNT_W-1:0] overlap_cycles;
  logic [CNT_W-1:0] send_bursts;
  logic [CNT_W-1:0] recv_bursts;
  logic [PCT_W-1:0] overlap_pct;
  logic             div_zero;

  modport master (
    output ens, enr, start, stop,
    input  busy, done,
    input  send_cycles, recv_cycles,
    input  overlap_cycles,
    input  send_bursts, recv_bursts,
    input  overlap_pct, div_zero
  );

  modport slave (
    input  ens, enr, start, stop,
    output busy, done,
    output send_cycles, recv_cycles,
    output overlap_cycles,
    output send_bursts, recv_bursts,
    output overlap_pct, div_zero
  );

endinterface

// File: rtl/overlap_divider.sv
// Restoring divider, one quotient bit per cycle, MSB first.
// The load cycle also resolves the top bit.
module overlap_divider
  import enable_monitor_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [CNT_W+PCT_W-1:0] num,
  input  logic [CNT_W-1:0]       den,
  output logic                   busy,
  output logic                   valid,
  output logic [PCT_W-1:0]       quot,
  output logic                   zero
);

  localparam int NUM_W = CNT_W + PCT_W;

  logic [NUM_W-1:0] rem_q, rem_d, rem_in, dsh;
  logic [CNT_W-1:0] den_q, den_d, den_in;
  logic [2:0]       step_q, step_d, step_in;
  logic [PCT_W-1:0] quot_q, quot_d, quot_in;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             zero_q, zero_d;

  always_comb begin
    rem_in  = start ? num : rem_q;
    den_in  = start ? den : den_q;
    step_in = start ? 3'(DIV_STEPS - 1) : step_q;
    quot_in = start ? '0 : quot_q;
    dsh     = NUM_W'(den_in) << step_in;
    rem_d   = rem_q;
    den_d   = den_q;
    step_d  = step_q;
    quot_d  = quot_q;
    busy_d  = busy_q;
    zero_d  = zero_q;
    valid_d = 1'b0;
    if (start || busy_q) begin
      den_d  = den_in;
      zero_d = (den_in == '0);
      rem_d  = rem_in;
      quot_d = quot_in;
      if (rem_in >= dsh) begin
        rem_d          = rem_in - dsh;
        quot_d[step_in] = 1'b1;
      end
      busy_d  = (step_in != 3'd0);
      valid_d = (step_in == 3'd0);
      step_d  = step_in - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q   <= '0;
      den_q   <= '0;
      step_q  <= '0;
      quot_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      rem_q   <= rem_d;
      den_q   <= den_d;
      step_q  <= step_d;
      quot_q  <= quot_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      zero_q  <= zero_d;
    end
  end

  // A zero divisor sets every bit above; the flag masks it.
  assign quot  = zero_q ? '0 : quot_q;
  assign zero  = zero_q;
  assign busy  = busy_q;
  assign valid = valid_q;

endmodule

// File: rtl/enable_overlap_monitor.sv
// Counts synced ens/enr activity over a start/stop window,
// then derives the overlap percentage with a serial divider.
module enable_overlap_monitor
  import enable_monitor_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  enable_overlap_monitor_if.slave  bus
);

  localparam int NUM_W = CNT_W + PCT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  mon_state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] ens_sync_q, ens_sync_d;
  logic [SYNC_STAGES-1:0] enr_sync_q, enr_sync_d;
  logic ens_prev_q, ens_prev_d;
  logic enr_prev_q, enr_prev_d;
  logic [CNT_W-1:0] send_q, send_d;
  logic [CNT_W-1:0] recv_q, recv_d;
  logic [CNT_W-1:0] ovl_q, ovl_d;
  logic [CNT_W-1:0] sbur_q, sbur_d;
  logic [CNT_W-1:0] rbur_q, rbur_d;
  logic [PCT_W-1:0] pct_q, pct_d;
  logic zero_q, zero_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic div_go_q, div_go_d;

  logic             ens_s, enr_s;
  logic             div_busy, div_valid, div_zero;
  logic [PCT_W-1:0] div_quot;
  logic [NUM_W-1:0] div_num;
  logic [CNT_W-1:0] div_den;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] c,
    input logic             hit
  );
    return (hit && c != CNT_MAX) ? c + 1'b1 : c;
  endfunction

  assign ens_s   = ens_sync_q[SYNC_STAGES-1];
  assign enr_s   = enr_sync_q[SYNC_STAGES-1];
  assign div_num = NUM_W'(ovl_q) * NUM_W'(PCT_SCALE);
  assign div_den = (send_q >= recv_q) ? send_q : recv_q;

  always_comb begin
    ens_sync_d = {ens_sync_q[SYNC_STAGES-2:0], bus.ens};
    enr_sync_d = {enr_sync_q[SYNC_STAGES-2:0], bus.enr};
    state_d    = state_q;
    ens_prev_d = ens_prev_q;
    enr_prev_d = enr_prev_q;
    send_d     = send_q;
    recv_d     = recv_q;
    ovl_d      = ovl_q;
    sbur_d     = sbur_q;
    rbur_d     = rbur_q;
    pct_d      = pct_q;
    zero_d     = zero_q;
    div_go_d   = 1'b0;
    unique case (1'b1)
      (state_q == IDLE) || (state_q == DONE): begin
        if (bus.start) begin
          send_d     = '0;
          recv_d     = '0;
          ovl_d      = '0;
          sbur_d     = '0;
          rbur_d     = '0;
          pct_d      = '0;
          zero_d     = 1'b0;
          ens_prev_d = 1'b0;
          enr_prev_d = 1'b0;
          state_d    = MEASURE;
        end
      end
      (state_q == MEASURE): begin
        send_d     = sat_inc(send_q, ens_s);
        recv_d     = sat_inc(recv_q, enr_s);
        ovl_d      = sat_inc(ovl_q, ens_s && enr_s);
        sbur_d     = sat_inc(sbur_q, ens_s && !ens_prev_q);
        rbur_d     = sat_inc(rbur_q, enr_s && !enr_prev_q);
        ens_prev_d = ens_s;
        enr_prev_d = enr_s;
        if (bus.stop) begin
          state_d  = DIVIDE;
          div_go_d = !div_busy;
        end
      end
      (state_q == DIVIDE): begin
        if (div_valid) begin
          pct_d   = div_quot;
          zero_d  = div_zero;
          state_d = DONE;
        end
      end
      default: ;
    endcase
    busy_d = (state_d == MEASURE) || (state_d == DIVIDE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ens_sync_q <= '0;
      enr_sync_q <= '0;
      ens_prev_q <= 1'b0;
      enr_prev_q <= 1'b0;
      send_q     <= '0;
      recv_q     <= '0;
      ovl_q      <= '0;
      sbur_q     <= '0;
      rbur_q     <= '0;
      pct_q      <= '0;
      zero_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_go_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ens_sync_q <= ens_sync_d;
      enr_sync_q <= enr_sync_d;
      ens_prev_q <= ens_prev_d;
      enr_prev_q <= enr_prev_d;
      send_q     <= send_d;
      recv_q     <= recv_d;
      ovl_q      <= ovl_d;
      sbur_q     <= sbur_d;
      rbur_q     <= rbur_d;
      pct_q      <= pct_d;
      zero_q     <= zero_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_go_q   <= div_go_d;
    end
  end

  // Launched one cycle after stop so the last count is included.
  overlap_divider #(
    .CNT_W (CNT_W)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (div_go_q),
    .num   (div_num),
    .den   (div_den),
    .busy  (div_busy),
    .valid (div_valid),
    .quot  (div_quot),
    .zero  (div_zero)
  );

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.send_cycles    = send_q;
  assign bus.recv_cycles    = recv_q;
  assign bus.overlap_cycles = ovl_q;
  assign bus.send_bursts    = sbur_q;
  assign bus.recv_bursts    = rbur_q;
  assign bus.overlap_pct    = pct_q;
  assign bus.div_zero       = zero_q;

endmodule

// File: doc/enable_overlap_monitor.md
Name: enable_overlap_monitor

Overview:
- Clocked measurement block at the receiving end of the sender/receiver enable stimulus (ens, enr) used in the communication examples.
- Samples both enables, counts enabled cycles, overlap cycles and enable bursts over a start/stop window.
- After the window closes, a sequential divider computes the integer overlap percentage.
- Results are held for bench readout or for self-checking against each scenario's expected overlap (100/100/~67/50/0 %).

Parameters:
CNT_W, 16, width of every cycle/burst counter
SYNC_STAGES, 2, synchronizer depth on ens/enr (fixed ≥2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
ens  input  1  sender enable, asynchronous to clk
enr  input  1  receiver enable, asynchronous to clk
start  input  1  single-cycle pulse, opens measurement window
stop  input  1  single-cycle pulse, closes window
busy  output  1  high in MEASURE or DIVIDE
done  output  1  high in DONE (level)
send_cycles  output  CNT_W  cycles with synced ens=1
recv_cycles  output  CNT_W  cycles with synced enr=1
overlap_cycles  output  CNT_W  cycles with both=1
send_bursts  output  CNT_W  rising edges of synced ens
recv_bursts  output  CNT_W  rising edges of synced enr
overlap_pct  output  7  floor(100*overlap_cycles / max(send_cycles,recv_cycles)), 0..100
div_zero  output  1  max(send,recv)=0 at end of window

Behaviour:
- Reset (async assert, sync deassert handled outside): state IDLE; all counters, overlap_pct, div_zero, busy, done = 0; synchronizer flops and previous-sample flops = 0.
- ens/enr each pass through a SYNC_STAGES flop chain; all counting uses synced values only (pin-to-count latency = SYNC_STAGES cycles).
- FSM: IDLE, MEASURE, DIVIDE, DONE.
- IDLE/DONE + start: clear all counters, overlap_pct, div_zero; clear prev-sample flops to 0; next state MEASURE. The results of a previous DONE are lost.
- MEASURE: every cycle, including the cycle stop is high, increment each counter whose condition holds. Burst = synced value 1 while prev sample 0, so an enable already high at start counts as one burst.
- MEASURE + stop: next state DIVIDE.
- start in MEASURE/DIVIDE is ignored. stop outside MEASURE is ignored. start and stop together in IDLE/DONE: start wins, stop ignored.
- Counters saturate at 2^CNT_W-1; no wrap.
- DIVIDE: restoring division, exactly 7 cycles.
  - Numerator = overlap_cycles*100 (CNT_W+7 bits). Denominator D = max(send_cycles, recv_cycles).
  - Iteration i = 6..0: if remainder ≥ D<<i, subtract it and set quotient bit i.
  - If D=0: div_zero=1, quotient forced to 0, still 7 cycles.
  - Result is written to overlap_pct on entry to DONE.
- Timing: stop sampled at edge m → DIVIDE cycles m+1..m+7 → done=1 and outputs valid from edge m+8.
- DONE: all outputs frozen; held until the next start or reset.
- Reset mid-operation: immediate return to IDLE with reset values; no partial result is retained.
- Outputs are registered; only the count outputs change during MEASURE.

Decomposition:
- Package enable_monitor_pkg: FSM state enum (IDLE, MEASURE, DIVIDE, DONE), PCT_W=7, PCT_SCALE=100, DIV_STEPS=7.
- One natural sub-module: overlap_divider (start/busy/valid handshake, numerator/denominator in, 7-bit quotient and zero flag out).
- Synchronizer is inline.

Test Plan:
- Clock 10 ns. start; ens=enr=1 for 40 cycles; drop both 5 cycles before stop → send=recv=overlap=40, bursts 1/1, pct=100, done at stop+8.
- ens high cycles 10–29 and 50–69; enr high 20–39 and 60–79; stop at 90 → send=recv=40, overlap=20, bursts 2/2, pct=50.
- ens high 10–29 and 50–69; enr high 30–49 and 70–89 (no overlap) → overlap=0, pct=0, div_zero=0.
- start, no enables, stop → all counts 0, div_zero=1, pct=0, done after 8 cycles.
- CNT_W=4: ens=enr=1 for 20 cycles → counts saturate at 15, pct=100.
- Mid-MEASURE rst_n low 1 cycle → all outputs 0 immediately, state IDLE; a later stop is ignored (done stays 0); start during DIVIDE is ignored.
